// File: rtl/hilo_div_ctrl.sv
// HI/LO register owner with a multi-cycle restoring unsigned divider.
// Resolves RADIX_BITS quotient bits per cycle and stalls HI/LO traffic while dividing.
module hilo_div_ctrl #(
    parameter int WIDTH      = 32,
    parameter int RADIX_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_start,
    input  logic [WIDTH-1:0] div_a,
    input  logic [WIDTH-1:0] div_b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    input  logic             mf_req,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int N  = WIDTH / RADIX_BITS;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d, dbz_q, dbz_d;
    logic [WIDTH:0]   trial_rem;
    logic [WIDTH-1:0] trial_quo;

    // dvd_q shifts dividend bits out at the top while quotient bits fill in at the bottom
    always_comb begin
        trial_rem = {1'b0, rem_q};
        trial_quo = dvd_q;
        for (int i = 0; i < RADIX_BITS; i++) begin
            trial_rem = {trial_rem[WIDTH-1:0], trial_quo[WIDTH-1]};
            trial_quo = {trial_quo[WIDTH-2:0], 1'b0};
            if (trial_rem >= {1'b0, dvs_q}) begin
                trial_rem    = trial_rem - {1'b0, dvs_q};
                trial_quo[0] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_RUN: begin
                dvd_d = trial_quo;
                rem_d = trial_rem[WIDTH-1:0];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    hi_d    = trial_rem[WIDTH-1:0];
                    lo_d    = trial_quo;
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    dbz_d   = 1'b0;
                end
            end
            default: begin
                if (mthi) hi_d = wdata;
                if (mtlo) lo_d = wdata;
                // A divide by zero commits on the accepting edge and wins over mthi/mtlo
                if (div_start && (div_b != '0)) begin
                    dvd_d   = div_a;
                    dvs_d   = div_b;
                    rem_d   = '0;
                    cnt_d   = CW'(N);
                    state_d = S_RUN;
                    done_d  = 1'b0;
                    dbz_d   = 1'b0;
                end else if (div_start) begin
                    hi_d    = div_a;
                    lo_d    = '1;
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    dbz_d   = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                    dbz_d   = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == S_RUN);
    assign stall       = busy & (mf_req | div_start | mthi | mtlo);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Bench for hilo_div_ctrl: three radix variants driven in lockstep, results scoreboarded.
module tb_hilo_div_ctrl;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst, div_start, mthi, mtlo, mf_req;
    logic [W-1:0] div_a, div_b, wdata;
    logic         stall_a [3];
    logic         busy_a  [3];
    logic         done_a  [3];
    logic         dbz_a   [3];
    logic [W-1:0] hi_a    [3];
    logic [W-1:0] lo_a    [3];

    exp_t sb [3][$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    hilo_div_ctrl #(.WIDTH(W), .RADIX_BITS(1)) u_r1 (
        .clk(clk), .rst(rst), .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .mf_req(mf_req),
        .stall(stall_a[0]), .busy(busy_a[0]), .done(done_a[0]),
        .div_by_zero(dbz_a[0]), .hi(hi_a[0]), .lo(lo_a[0])
    );
    hilo_div_ctrl #(.WIDTH(W), .RADIX_BITS(2)) u_r2 (
        .clk(clk), .rst(rst), .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .mf_req(mf_req),
        .stall(stall_a[1]), .busy(busy_a[1]), .done(done_a[1]),
        .div_by_zero(dbz_a[1]), .hi(hi_a[1]), .lo(lo_a[1])
    );
    hilo_div_ctrl #(.WIDTH(W), .RADIX_BITS(4)) u_r4 (
        .clk(clk), .rst(rst), .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .mf_req(mf_req),
        .stall(stall_a[2]), .busy(busy_a[2]), .done(done_a[2]),
        .div_by_zero(dbz_a[2]), .hi(hi_a[2]), .lo(lo_a[2])
    );

    function automatic int n_of(input int k);
        return (k == 0) ? 32 : (k == 1) ? 16 : 8;
    endfunction

    task automatic chk(input string tag, input int k, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s[r%0d] observed=%h expected=%h", tag, 1 << k, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk({tag, "_hi"}, k, hi_a[k], '0);
            chk({tag, "_lo"}, k, lo_a[k], '0);
            chk({tag, "_busy"}, k, W'(busy_a[k]), '0);
            chk({tag, "_stall"}, k, W'(stall_a[k]), '0);
            chk({tag, "_done"}, k, W'(done_a[k]), '0);
        end
    endtask

    // mode 0 plain, 1 mf_req held from cycle 3, 2 mthi during RUN, 3 second div_start while busy
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input int mode);
        int           busy_cnt [3];
        int           lat;
        logic [W-1:0] hi0 [3];
        logic [W-1:0] lo0 [3];
        logic         req;
        exp_t         e, got;
        @(negedge clk);
        e.hi  = (b == 0) ? a : a % b;
        e.lo  = (b == 0) ? '1 : a / b;
        e.dbz = (b == 0);
        for (int k = 0; k < 3; k++) begin
            hi0[k]      = hi_a[k];
            lo0[k]      = lo_a[k];
            busy_cnt[k] = 0;
            sb[k].push_back(e);
        end
        div_a = a; div_b = b; div_start = 1'b1;
        @(negedge clk);
        div_start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            mf_req    = (mode == 1) && (c >= 2);
            mthi      = (mode == 2) && (c >= 2) && (c <= 6);
            wdata     = 32'hA5A5A5A5;
            div_start = (mode == 3) && (c == 3);
            if (div_start) begin
                div_a = 32'h0000_0010; div_b = 32'h0000_0003;
            end
            req = mf_req | mthi | div_start;
            #1;
            for (int k = 0; k < 3; k++) begin
                lat = (b == 0) ? 0 : n_of(k);
                chk("stall", k, W'(stall_a[k]), W'((c < lat) && req));
                if (busy_a[k]) begin
                    busy_cnt[k]++;
                    chk("hi_hold", k, hi_a[k], hi0[k]);
                    chk("lo_hold", k, lo_a[k], lo0[k]);
                end
                if (done_a[k]) begin
                    chk("done_cycle", k, W'(c), W'(lat));
                    if (sb[k].size() == 0) begin
                        chk("done_unexpected", k, W'(done_a[k]), '0);
                    end else begin
                        got = sb[k].pop_front();
                        chk("hi", k, hi_a[k], got.hi);
                        chk("lo", k, lo_a[k], got.lo);
                        chk("dbz", k, W'(dbz_a[k]), W'(got.dbz));
                    end
                end
            end
            @(negedge clk);
        end
        mf_req = 1'b0; mthi = 1'b0; div_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("busy_cycles", k, W'(busy_cnt[k]), W'((b == 0) ? 0 : n_of(k)));
            chk("missing_done", k, W'(sb[k].size()), '0);
            sb[k].delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] lo_prev [3];
        logic [W-1:0] ra, rb;
        int           dcnt;
        rst = 1'b0; div_start = 1'b0; mthi = 1'b0; mtlo = 1'b0; mf_req = 1'b0;
        div_a = '0; div_b = '0; wdata = '0;
        #1;
        chk_idle_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run_div(32'd100, 32'd7, 0);
        run_div(32'h0000_1234, 32'd0, 0);
        run_div(32'd100, 32'd7, 1);

        // mthi/mtlo in IDLE
        @(negedge clk);
        for (int k = 0; k < 3; k++) lo_prev[k] = lo_a[k];
        mthi = 1'b1; wdata = 32'hA5A5A5A5;
        @(negedge clk);
        mthi = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("mthi_hi", k, hi_a[k], 32'hA5A5A5A5);
            chk("mthi_lo", k, lo_a[k], lo_prev[k]);
        end
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h5A5A_0F0F;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("mthilo_hi", k, hi_a[k], 32'h5A5A_0F0F);
            chk("mthilo_lo", k, lo_a[k], 32'h5A5A_0F0F);
        end

        run_div(32'd1000, 32'd33, 2);
        run_div(32'd77, 32'd5, 3);

        // asynchronous abort in the middle of a run
        @(negedge clk);
        div_a = '1; div_b = 32'd1; div_start = 1'b1;
        @(negedge clk);
        div_start = 1'b0;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 3; k++) chk("pre_abort_busy", k, W'(busy_a[k]), W'(1));
        #2 rst = 1'b0;
        #1;
        chk_idle_zero("abort");
        @(negedge clk);
        rst = 1'b1;
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) if (done_a[k] || busy_a[k]) dcnt++;
        end
        chk("abort_no_done", 0, W'(dcnt), '0);
        run_div('1, 32'd1, 0);

        run_div(32'd5, 32'd9, 0);
        run_div(32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
        run_div(32'h8000_0000, 32'd3, 0);
        run_div('1, '1, 0);
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = (i == 2) ? '0 : (i[0] ? $urandom : W'($urandom_range(1, 255)));
            run_div(ra, rb, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
